control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 39 +++
 rtl/cu_decode.sv | 37 +++
 rtl/control_unit.sv | 152 +++++++++++++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, ALU codes, FSM states and instruction classes
// Purpose: single source of encodings for the control unit and its decoder.
// Ports: none (package).
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd8;
    localparam logic [3:0] ALU_SUB = 4'd9;

    localparam logic [1:0] MDR_SRC_BUS = 2'b00;
    localparam logic [1:0] MDR_SRC_MEM = 2'b01;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    // Instructions grouped by the shape of their execute sequence.
    typedef enum logic [3:0] {
        CLS_NOP, CLS_REG, CLS_IMM, CLS_LD, CLS_ST, CLS_BR, CLS_HALT, CLS_IN, CLS_OUT
    } instr_class_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - combinational opcode to instruction-class / ALU-op decoder
// Purpose: classify IR[31:27] and pick the ALU operation used in T4.
// Ports: opcode (in, 5) ; instr_class (out, class enum) ; alu_op (out, 4).
// Optional feature: CU_IO_EN enables the in/out opcodes; otherwise they decode as nop.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t instr_class,
    output logic [3:0]   alu_op
);

    always_comb begin
        instr_class = CLS_NOP;
        alu_op      = ALU_ADD;
        case (opcode)
            OP_ADD:  instr_class = CLS_REG;
            OP_SUB:  begin instr_class = CLS_REG; alu_op = ALU_SUB; end
            OP_AND:  begin instr_class = CLS_REG; alu_op = ALU_AND; end
            OP_OR:   begin instr_class = CLS_REG; alu_op = ALU_OR;  end
            OP_ADDI: instr_class = CLS_IMM;
            OP_ANDI: begin instr_class = CLS_IMM; alu_op = ALU_AND; end
            OP_ORI:  begin instr_class = CLS_IMM; alu_op = ALU_OR;  end
            OP_LDI:  instr_class = CLS_IMM;
            OP_LD:   instr_class = CLS_LD;
            OP_ST:   instr_class = CLS_ST;
            OP_BR:   instr_class = CLS_BR;
            OP_HALT: instr_class = CLS_HALT;
`ifdef CU_IO_EN
            OP_IN:   instr_class = CLS_IN;
            OP_OUT:  instr_class = CLS_OUT;
`endif
            default: instr_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control sequencer for the fetch/execute datapath
// Purpose: steps RST -> T0..T7 -> T0/HALT and decodes datapath strobes from state and IR.
// Ports: clk, reset (sync, active-high), IR[31:0], Branch, stop (in);
//        PC/memory/register/select strobes, mdr_read[1:0], control[3:0],
//        InPortout, OutPortin, run (out).
// Optional feature: CU_IO_EN enables in/out instructions; otherwise the port strobes stay 0.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        Branch,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPc,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        read,
    output logic        write,
    output logic [1:0]  mdr_read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        CONin,
    output logic        GRA,
    output logic        GRB,
    output logic        GRC,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic [3:0]  control,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        run
);

    state_t       state, next_state;
    instr_class_t instr_class;
    logic [3:0]   alu_op;
    logic         instr_done;

    // Operand fields (including C2) feed the datapath's select/encode logic, not this block.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    cu_decode u_decode (
        .opcode      (IR[31:27]),
        .instr_class (instr_class),
        .alu_op      (alu_op)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RST;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        instr_done = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPc = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; read = 1'b0; write = 1'b0;
        mdr_read = MDR_SRC_BUS;
        IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0; Zlowout = 1'b0; CONin = 1'b0;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; control = 4'd0;
        InPortout = 1'b0; OutPortin = 1'b0;
        run = (state != ST_RST) && (state != ST_HALT);

        case (state)
            ST_RST: next_state = ST_T0;
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zlowin = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; read = 1'b1;
                mdr_read = MDR_SRC_MEM; MDRin = 1'b1;
                next_state = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                case (instr_class)
                    CLS_NOP:  instr_done = 1'b1;
                    CLS_HALT: next_state = ST_HALT;
                    default:  next_state = ST_T3;
                endcase
            end
            ST_T3: begin
                next_state = ST_T4;
                case (instr_class)
                    CLS_REG: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CLS_IMM, CLS_LD, CLS_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CLS_BR:  begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
`ifdef CU_IO_EN
                    CLS_IN:  begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
                    CLS_OUT: begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; instr_done = 1'b1; end
`endif
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T4: begin
                next_state = ST_T5;
                case (instr_class)
                    CLS_REG: begin GRC = 1'b1; Rout = 1'b1; control = alu_op; Zlowin = 1'b1; end
                    CLS_IMM, CLS_LD, CLS_ST: begin Cout = 1'b1; control = alu_op; Zlowin = 1'b1; end
                    CLS_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T5: begin
                next_state = ST_T6;
                case (instr_class)
                    CLS_REG, CLS_IMM: begin Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1; instr_done = 1'b1; end
                    CLS_LD, CLS_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    CLS_BR:  begin Cout = 1'b1; control = ALU_ADD; Zlowin = 1'b1; end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T6: begin
                next_state = ST_T7;
                case (instr_class)
                    CLS_LD: begin read = 1'b1; mdr_read = MDR_SRC_MEM; MDRin = 1'b1; end
                    CLS_ST: begin GRA = 1'b1; Rout = 1'b1; mdr_read = MDR_SRC_BUS; MDRin = 1'b1; end
                    CLS_BR: begin
                        // Target only reaches the PC when the CON flip-flop says take it.
                        Zlowout = Branch; PCin = Branch; instr_done = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            ST_T7: begin
                instr_done = 1'b1;
                case (instr_class)
                    CLS_LD:  begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
                    CLS_ST:  write = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_RST;
        endcase

        // stop is only honoured at an instruction boundary.
        if (instr_done) next_state = stop ? ST_HALT : ST_T0;
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        Branch = 1'b0;
    logic        stop = 1'b0;
    logic PCout, PCin, IncPc, MARin, MDRin, MDRout, read, write;
    logic [1:0] mdr_read;
    logic IRin, Yin, Zlowin, Zlowout, CONin, GRA, GRB, GRC, Rin, Rout, BAout, Cout;
    logic [3:0] control;
    logic InPortout, OutPortin, run;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .IR(IR), .Branch(Branch), .stop(stop),
        .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .read(read), .write(write), .mdr_read(mdr_read),
        .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .CONin(CONin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .control(control), .InPortout(InPortout), .OutPortin(OutPortin),
        .run(run)
    );

    logic [31:0] obs;
    assign obs = {3'b000, run, OutPortin, InPortout, control, Cout, BAout, Rout, Rin,
                  GRC, GRB, GRA, CONin, Zlowout, Zlowin, Yin, IRin, mdr_read, write,
                  read, MDRout, MDRin, MARin, IncPc, PCin, PCout};

    localparam logic [31:0] M_PCOUT = 32'd1 << 0,  M_PCIN  = 32'd1 << 1,  M_INCPC = 32'd1 << 2;
    localparam logic [31:0] M_MARIN = 32'd1 << 3,  M_MDRIN = 32'd1 << 4,  M_MDROUT = 32'd1 << 5;
    localparam logic [31:0] M_READ  = 32'd1 << 6,  M_WRITE = 32'd1 << 7,  M_MDR01 = 32'd1 << 8;
    localparam logic [31:0] M_IRIN  = 32'd1 << 10, M_YIN   = 32'd1 << 11, M_ZLIN  = 32'd1 << 12;
    localparam logic [31:0] M_ZLOUT = 32'd1 << 13, M_CONIN = 32'd1 << 14, M_GRA   = 32'd1 << 15;
    localparam logic [31:0] M_GRB   = 32'd1 << 16, M_GRC   = 32'd1 << 17, M_RIN   = 32'd1 << 18;
    localparam logic [31:0] M_ROUT  = 32'd1 << 19, M_BAOUT = 32'd1 << 20, M_COUT  = 32'd1 << 21;
    localparam logic [31:0] M_INP   = 32'd1 << 26, M_OUTP  = 32'd1 << 27, M_RUN   = 32'd1 << 28;

    localparam logic [31:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLIN | M_RUN;
    localparam logic [31:0] W_T1 = M_ZLOUT | M_PCIN | M_READ | M_MDR01 | M_MDRIN | M_RUN;
    localparam logic [31:0] W_T2 = M_MDROUT | M_IRIN | M_RUN;

    function automatic logic [31:0] ctl(input int v);
        return 32'(v) << 22;
    endfunction

    int vec_count = 0;
    int err_count = 0;
    logic [31:0] exp_q[$];
    bit ends_halt;

    task automatic check(input string name, input logic [31:0] expv);
        vec_count++;
        if (obs !== expv) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", name, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] w);
        exp_q.push_back(w | M_RUN);
    endtask

    // Reference: the per-cycle strobe listing of each instruction, fetch included.
    task automatic build_seq(input logic [4:0] op, input bit br);
        int alu;
        exp_q.delete();
        exp_q.push_back(W_T0); exp_q.push_back(W_T1); exp_q.push_back(W_T2);
        ends_halt = 1'b0;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                alu = (op == 5'd3) ? 8 : (op == 5'd4) ? 9 : (op == 5'd5) ? 1 : 2;
                push(M_GRB | M_ROUT | M_YIN);
                push(M_GRC | M_ROUT | ctl(alu) | M_ZLIN);
                push(M_ZLOUT | M_GRA | M_RIN);
            end
            5'd12, 5'd13, 5'd14, 5'd1: begin
                alu = (op == 5'd13) ? 1 : (op == 5'd14) ? 2 : 8;
                push(M_GRB | M_BAOUT | M_YIN);
                push(M_COUT | ctl(alu) | M_ZLIN);
                push(M_ZLOUT | M_GRA | M_RIN);
            end
            5'd0, 5'd2: begin
                push(M_GRB | M_BAOUT | M_YIN);
                push(M_COUT | ctl(8) | M_ZLIN);
                push(M_ZLOUT | M_MARIN);
                if (op == 5'd0) begin
                    push(M_READ | M_MDR01 | M_MDRIN);
                    push(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN);
                    push(M_WRITE);
                end
            end
            5'd18: begin
                push(M_GRA | M_ROUT | M_CONIN);
                push(M_PCOUT | M_YIN);
                push(M_COUT | ctl(8) | M_ZLIN);
                push(br ? (M_ZLOUT | M_PCIN) : 32'd0);
            end
            5'd25: ends_halt = 1'b1;
`ifdef CU_IO_EN
            5'd22: push(M_INP | M_GRA | M_RIN);
            5'd23: push(M_GRA | M_ROUT | M_OUTP);
`endif
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_state", 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_then_t0", W_T0);
    endtask

    // Entered and left at a negedge with T0 visible (or via reset after HALT).
    task automatic run_instr(input logic [4:0] op, input bit br, input bit stp,
                             input int abort_at, input string tag);
        IR = {op, 27'($urandom)};
        Branch = br;
        stop = stp;
        build_seq(op, br);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_op%0d_c%0d", tag, op, i), exp_q[i]);
            if (i == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check({tag, "_abort_rst"}, 32'd0);
                reset = 1'b0;
                stop = 1'b0;
                @(negedge clk);
                check({tag, "_abort_t0"}, W_T0);
                return;
            end
            @(negedge clk);
        end
        if (ends_halt || stp) begin
            check({tag, "_halt"}, 32'd0);
            stop = 1'b0;
            @(negedge clk);
            check({tag, "_halt_hold"}, 32'd0);
            @(negedge clk);
            check({tag, "_halt_hold2"}, 32'd0);
            do_reset();
        end else begin
            check({tag, "_latency_t0"}, W_T0);
        end
    endtask

    typedef struct {
        logic [31:0] ir;
        bit          br;
        int          step;
        logic [31:0] expv;
        string       name;
    } tv_t;

    tv_t tbl[$];

    initial begin
        tbl.push_back('{32'h18918000, 1'b0, 4, M_GRC | M_ROUT | ctl(8) | M_ZLIN | M_RUN, "add_t4"});
        tbl.push_back('{32'h18918000, 1'b0, 5, M_ZLOUT | M_GRA | M_RIN | M_RUN, "add_t5"});
        tbl.push_back('{32'h18918000, 1'b0, 6, W_T0, "add_lat6"});
        tbl.push_back('{32'h20000000, 1'b0, 4, M_GRC | M_ROUT | ctl(9) | M_ZLIN | M_RUN, "sub_t4"});
        tbl.push_back('{32'h28000000, 1'b0, 4, M_GRC | M_ROUT | ctl(1) | M_ZLIN | M_RUN, "and_t4"});
        tbl.push_back('{32'h7118001A, 1'b0, 3, M_GRB | M_BAOUT | M_YIN | M_RUN, "ori_t3"});
        tbl.push_back('{32'h7118001A, 1'b0, 4, M_COUT | ctl(2) | M_ZLIN | M_RUN, "ori_t4"});
        tbl.push_back('{32'h08000005, 1'b0, 4, M_COUT | ctl(8) | M_ZLIN | M_RUN, "ldi_t4"});
        tbl.push_back('{32'h90000000, 1'b0, 6, M_RUN, "br_nt_t6"});
        tbl.push_back('{32'h90000000, 1'b1, 6, M_ZLOUT | M_PCIN | M_RUN, "br_t_t6"});
        tbl.push_back('{32'h90000000, 1'b1, 7, W_T0, "br_lat7"});
        tbl.push_back('{32'h00000000, 1'b0, 6, M_READ | M_MDR01 | M_MDRIN | M_RUN, "ld_t6"});
        tbl.push_back('{32'h00000000, 1'b0, 7, M_MDROUT | M_GRA | M_RIN | M_RUN, "ld_t7"});
        tbl.push_back('{32'h00000000, 1'b0, 8, W_T0, "ld_lat8"});
        tbl.push_back('{32'h10000000, 1'b0, 6, M_GRA | M_ROUT | M_MDRIN | M_RUN, "st_t6"});
        tbl.push_back('{32'h10000000, 1'b0, 7, M_WRITE | M_RUN, "st_t7"});
        tbl.push_back('{32'hC0000000, 1'b0, 3, W_T0, "nop_lat3"});
        tbl.push_back('{32'hF8000000, 1'b0, 3, W_T0, "undef_lat3"});
        tbl.push_back('{32'hC8000000, 1'b0, 3, 32'd0, "halt_t3"});
        tbl.push_back('{32'hB0000000, 1'b0, 2, W_T2, "in_t2"});
`ifdef CU_IO_EN
        tbl.push_back('{32'hB0000000, 1'b0, 3, M_INP | M_GRA | M_RIN | M_RUN, "in_t3"});
        tbl.push_back('{32'hB8000000, 1'b0, 3, M_GRA | M_ROUT | M_OUTP | M_RUN, "out_t3"});
`else
        tbl.push_back('{32'hB0000000, 1'b0, 3, W_T0, "in_as_nop"});
        tbl.push_back('{32'hB8000000, 1'b0, 3, W_T0, "out_as_nop"});
`endif

        for (int k = 0; k < tbl.size(); k++) begin
            do_reset();
            IR = tbl[k].ir;
            Branch = tbl[k].br;
            stop = 1'b0;
            repeat (tbl[k].step) @(negedge clk);
            check(tbl[k].name, tbl[k].expv);
        end

        do_reset();
        run_instr(5'd2, 1'b0, 1'b1, -1, "st_stop");
        run_instr(5'd0, 1'b0, 1'b0, 6, "ld_abort");
        run_instr(5'd22, 1'b0, 1'b0, -1, "io_in");
        run_instr(5'd18, 1'b1, 1'b0, -1, "br_taken");
        run_instr(5'd24, 1'b0, 1'b1, -1, "nop_stop");

        for (int n = 0; n < 60; n++) begin
            run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), -1, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
